// File: rtl/arb_pkg.sv
// Shared definitions for the arbitrated transfer engine: FSM encoding and
// the burst-length decode rule.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A zero length field stands for the full 2**lw beats.
    function automatic int decode_len(input int len, input int lw);
        return (len == 0) ? (1 << lw) : len;
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Beat counter: cleared on load, advances by one per enabled cycle, and flags
// when the current beat is the final one of the latched burst.
module beat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W:0]   limit_i,
    output logic         term_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // limit_i is W+1 bits wide so a full 2**W burst terminates at cnt == 2**W-1.
    assign term_o = ({1'b0, cnt_q} == (limit_i - 1'b1));

endmodule

// File: rtl/arb_xfer_engine.sv
// Moves one granted client's burst to a single downstream port, reporting
// completion, grant-loss aborts and conflicting grants.
module arb_xfer_engine
    import arb_pkg::*;
#(
    parameter int DW = 8,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gnt_0,
    input  logic          gnt_1,
    input  logic [LW-1:0] len_0,
    input  logic [LW-1:0] len_1,
    input  logic [DW-1:0] data_0,
    input  logic [DW-1:0] data_1,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_src,
    output logic          out_last,
    output logic          done_0,
    output logic          done_1,
    output logic          abort,
    output logic          busy,
    output logic          gnt_err
);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [LW:0]   beats_q, beats_d;
    logic          gnt_err_q, gnt_err_d;
    logic          cnt_load, cnt_en, cnt_term;
    logic          own_gnt, other_gnt;
    logic          valid_c, last_c, done0_c, done1_c, abort_c;

    assign own_gnt   = owner_q ? gnt_1 : gnt_0;
    assign other_gnt = owner_q ? gnt_0 : gnt_1;

    beat_counter #(.W(LW)) u_beat_counter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (cnt_load),
        .en_i    (cnt_en),
        .limit_i (beats_q),
        .term_o  (cnt_term)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        beats_d   = beats_q;
        gnt_err_d = gnt_err_q;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        valid_c   = 1'b0;
        last_c    = 1'b0;
        done0_c   = 1'b0;
        done1_c   = 1'b0;
        abort_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_0 || gnt_1) begin
                    // Client 0 wins a simultaneous grant.
                    owner_d  = !gnt_0;
                    beats_d  = (LW+1)'(decode_len(int'(gnt_0 ? len_0 : len_1), LW));
                    cnt_load = 1'b1;
                    state_d  = ST_XFER;
                    if (gnt_0 && gnt_1) gnt_err_d = 1'b1;
                end
            end
            ST_XFER: begin
                valid_c = 1'b1;
                last_c  = cnt_term;
                cnt_en  = out_ready;
                if (other_gnt) gnt_err_d = 1'b1;
                if (out_ready && cnt_term) begin
                    state_d = ST_DONE;
                end else if (!out_ready && !own_gnt) begin
                    abort_c = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                done0_c = !owner_q;
                done1_c = owner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            beats_q   <= '0;
            gnt_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            beats_q   <= beats_d;
            gnt_err_q <= gnt_err_d;
        end
    end

    // Outputs are forced low while reset is asserted, not just after the edge.
    assign out_valid = valid_c & ~rst;
    assign out_last  = last_c & ~rst;
    assign out_src   = owner_q & (state_q == ST_XFER) & ~rst;
    assign out_data  = owner_q ? data_1 : data_0;
    assign done_0    = done0_c & ~rst;
    assign done_1    = done1_c & ~rst;
    assign abort     = abort_c & ~rst;
    assign busy      = (state_q != ST_IDLE) & ~rst;
    assign gnt_err   = gnt_err_q;

endmodule

// File: tb/tb_arb_xfer_engine.sv
// Scoreboard bench for arb_xfer_engine: directed bursts push expected beats
// and pulses; a negedge monitor pops and compares what the DUT presents.
module tb_arb_xfer_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       gnt_0, gnt_1;
    logic [3:0] len_0, len_1;
    logic [7:0] data_0, data_1;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_src, out_last;
    logic       done_0, done_1, abort, busy, gnt_err;

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q[$];   // {src, data, last}
    logic [2:0] ev_q[$];    // {abort, done_1, done_0}

    arb_xfer_engine #(.DW(8), .LW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .gnt_0     (gnt_0),
        .gnt_1     (gnt_1),
        .len_0     (len_0),
        .len_1     (len_1),
        .data_0    (data_0),
        .data_1    (data_1),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .done_0    (done_0),
        .done_1    (done_1),
        .abort     (abort),
        .busy      (busy),
        .gnt_err   (gnt_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: beats are checked whenever presented (stall stability), popped on acceptance.
    initial begin
        logic [9:0] got;
        logic [2:0] ev;
        forever begin
            @(negedge clk);
            got = {out_src, out_data, out_last};
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    if (out_ready) begin
                        checks++;
                        failures++;
                        $display("FAIL beat_unexpected: got %0h expected none", got);
                    end
                end else begin
                    checks++;
                    if (got !== exp_q[0]) begin
                        failures++;
                        $display("FAIL beat: got %0h expected %0h", got, exp_q[0]);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            ev = {abort, done_1, done_0};
            if (ev != 3'b000) begin
                checks++;
                if (ev_q.size() == 0) begin
                    failures++;
                    $display("FAIL pulse_unexpected: got %0b expected none", ev);
                end else begin
                    if (ev !== ev_q[0]) begin
                        failures++;
                        $display("FAIL pulse: got %0b expected %0b", ev, ev_q[0]);
                    end
                    void'(ev_q.pop_front());
                end
            end
        end
    end

    task automatic run_burst(input bit who, input logic [3:0] lenf, input int nbeats,
                             input bit toggle, input bit both);
        logic [7:0] base;
        int beat, cyc;
        bit r;
        base = who ? 8'h80 : 8'h10;
        @(posedge clk); #1;
        for (int b = 0; b < nbeats; b++)
            exp_q.push_back({who, base + 8'(b), (b == nbeats - 1)});
        ev_q.push_back(who ? 3'b010 : 3'b001);
        if (who) begin gnt_1 = 1'b1; len_1 = lenf; data_1 = base; end
        else     begin gnt_0 = 1'b1; len_0 = lenf; data_0 = base; end
        if (both) begin gnt_0 = 1'b1; gnt_1 = 1'b1; end
        out_ready = 1'b0;
        @(posedge clk); #1;
        if (who) len_1 = ~lenf; else len_0 = ~lenf;
        beat = 0;
        cyc  = 0;
        while (beat < nbeats && cyc < 100) begin
            r = toggle ? (cyc % 2 == 0) : 1'b1;
            out_ready = r;
            if (who) data_1 = base + 8'(beat); else data_0 = base + 8'(beat);
            @(posedge clk); #1;
            if (r) beat++;
            cyc++;
        end
        if (beat < nbeats) begin
            checks++;
            failures++;
            $display("FAIL burst_timeout: got %0d beats expected %0d", beat, nbeats);
        end
        gnt_0 = 1'b0;
        gnt_1 = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("busy_in_done", busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_after_done", {out_valid, busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; gnt_0 = 1'b0; gnt_1 = 1'b0; len_0 = '0; len_1 = '0;
        data_0 = '0; data_1 = '0; out_ready = 1'b0;

        // Reset held for two cycles
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        chk("reset_outputs",
            {out_valid, out_last, out_src, done_0, done_1, abort, busy, gnt_err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 3-beat burst from client 0, always ready
        run_burst(1'b0, 4'd3, 3, 1'b0, 1'b0);
        // 16-beat burst (len 0) from client 1, ready toggling
        run_burst(1'b1, 4'd0, 16, 1'b1, 1'b0);
        chk("gnt_err_clear", gnt_err, 0);
        // Simultaneous grants: client 0 served, conflict flagged
        run_burst(1'b0, 4'd2, 2, 1'b0, 1'b1);
        chk("gnt_err_set", gnt_err, 1);

        // Grant loss after two beats with downstream stalled
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 8'h10, 1'b0});
        exp_q.push_back({1'b0, 8'h11, 1'b0});
        ev_q.push_back(3'b100);
        gnt_0 = 1'b1; len_0 = 4'd5; data_0 = 8'h10; out_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        data_0 = 8'h11;
        @(posedge clk); #1;
        data_0 = 8'h12; gnt_0 = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("abort_pulse", abort, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_idle", {out_valid, busy, done_0, abort}, 0);
        chk("gnt_err_sticky", gnt_err, 1);

        // Reset during beat 2 of a 4-beat burst
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 8'h10, 1'b0});
        gnt_0 = 1'b1; len_0 = 4'd4; data_0 = 8'h10; out_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        data_0 = 8'h11; rst = 1'b1;
        @(negedge clk);
        chk("outputs_in_reset", {out_valid, out_last, out_src, done_0, done_1, abort, busy}, 0);
        @(posedge clk); #1;
        rst = 1'b0; gnt_0 = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("outputs_after_reset", {out_valid, out_last, out_src, done_0, done_1, abort, busy}, 0);
        chk("gnt_err_reset", gnt_err, 0);
        run_burst(1'b1, 4'd2, 2, 1'b0, 1'b0);

        @(posedge clk); #1;
        @(negedge clk);
        chk("beats_drained", exp_q.size(), 0);
        chk("pulses_drained", ev_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
